hilo_unit: RTL

- Owns the architectural HI/LO register pair of the MIPS datapath.
- Sits directly downstream of the iterative divider: sequences its start handshake, consumes its quotient and remainder, and stalls the pipeline while a divide is in flight.
- Also services MTHI/MTLO writes and drives HI/LO to the MFHI/MFLO read mux.
- Detects divide-by-zero locally and watchdogs the divider.

---
 rtl/hilo_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/hilo_unit.sv
// HI/LO architectural register pair: sequences the iterative divider, services
// MTHI/MTLO, flags divide-by-zero and aborts a divider that never finishes.
module hilo_unit #(
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_div,
    input  logic        op_mthi,
    input  logic        op_mtlo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        div_start,
    output logic [31:0] dividend,
    output logic [31:0] divisor,
    input  logic        div_end,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        stall,
    output logic        div0_exc,
    output logic        div_timeout
);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_TIMEOUT - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [31:0]      hi_nx, lo_nx, dividend_nx, divisor_nx;
    logic             start_nx, exc_nx, to_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            hi_out      <= '0;
            lo_out      <= '0;
            dividend    <= '0;
            divisor     <= '0;
            div_start   <= 1'b0;
            div0_exc    <= 1'b0;
            div_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            hi_out      <= hi_nx;
            lo_out      <= lo_nx;
            dividend    <= dividend_nx;
            divisor     <= divisor_nx;
            div_start   <= start_nx;
            div0_exc    <= exc_nx;
            div_timeout <= to_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        hi_nx       = hi_out;
        lo_nx       = lo_out;
        dividend_nx = dividend;
        divisor_nx  = divisor;
        start_nx    = 1'b0;
        exc_nx      = 1'b0;
        to_nx       = 1'b0;
        case (state)
            IDLE: begin
                if (op_div) begin
                    if (rt_data != 32'd0) begin
                        dividend_nx = rs_data;
                        divisor_nx  = rt_data;
                        start_nx    = 1'b1;
                        state_nx    = START;
                    end else begin
                        exc_nx = 1'b1;
                    end
                end else if (op_mthi) begin
                    hi_nx = rs_data;
                end else if (op_mtlo) begin
                    lo_nx = rs_data;
                end
            end
            START: begin
                cnt_nx   = '0;
                state_nx = WAIT;
            end
            WAIT: begin
                // First WAIT cycle may still see the previous divide's done level.
                if (cnt != '0 && div_end) begin
                    hi_nx    = div_hi;
                    lo_nx    = div_lo;
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    to_nx    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign stall = (state != IDLE);

endmodule
